// File: rtl/seg_pkg.sv
// seg_pkg: scanner FSM encoding and active-low {g,f,e,d,c,b,a} hex glyph table.
package seg_pkg;
    typedef enum logic [1:0] {BLANK, LOAD, SHOW} state_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = GLYPHS[nib];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode display driver with inter-digit blanking.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(BLANK_CYCLES + 1);

    state_t          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [3:0]      nib, nib_d;
    logic            dpl, dpl_d, enl, enl_d;
    logic            scan_q, tick, lz, show_d;
    logic [6:0]      glyph;

    assign tick   = scan_clk & ~scan_q;
    assign show_d = (state_d == SHOW);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign lz = (idx != '0) && ((value >> (4 * idx)) == '0);
`else
    assign lz = 1'b0;
`endif

    // Decode the nibble that will be on display after this edge so outputs stay registered
    hex_to_seg7 u_dec (
        .nib (nib_d),
        .seg (glyph)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        nib_d   = nib;
        dpl_d   = dpl;
        enl_d   = enl;
        case (state)
            BLANK: begin
                cnt_d = cnt + 1'b1;
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                nib_d   = value[4*idx +: 4];
                dpl_d   = dp_in[idx];
                enl_d   = digit_en[idx] & ~lz;
                state_d = SHOW;
            end
            SHOW: begin
                if (tick) begin
                    state_d = BLANK;
                    idx_d   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            idx    <= '0;
            cnt    <= '0;
            scan_q <= 1'b0;
            nib    <= '0;
            dpl    <= 1'b0;
            enl    <= 1'b0;
            an     <= '1;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            cnt    <= cnt_d;
            scan_q <= scan_clk;
            nib    <= nib_d;
            dpl    <= dpl_d;
            enl    <= enl_d;
            an     <= show_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
            seg    <= (show_d && enl_d) ? glyph : SEG_OFF;
            dp     <= (show_d && enl_d) ? ~dpl_d : 1'b1;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: randomized bench against a slot-timeline model of the scanner.
module tb_seven_seg_scanner;
    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           scan_clk = 1'b0;
    logic [4*N-1:0] value = '0;
    logic [N-1:0]   dp_in = '0;
    logic [N-1:0]   digit_en = '1;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp;

    int errors = 0;
    int checks = 0;

    seven_seg_scanner #(.NUM_DIGITS(N), .BLANK_CYCLES(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_clk (scan_clk),
        .value    (value),
        .dp_in    (dp_in),
        .digit_en (digit_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Lit segments, active-high, bit order {g,f,e,d,c,b,a}
    logic [6:0] lit [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int             n, light_at, m_digit, half, hcnt;
    bit             m_lit, prev_scan;
    logic [4*N-1:0] s_value;
    logic [N-1:0]   s_dp, s_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        light_at = B + 1;
        m_digit = 0;
        m_lit = 0;
        prev_scan = 0;
        hcnt = 0;
    endtask

    // A digit lights B+1 edges after its slot starts; a rising scan edge ends a lit slot only
    task automatic model_step();
        bit tk;
        n++;
        tk = scan_clk && !prev_scan;
        prev_scan = scan_clk;
        if (m_lit && tk) begin
            m_lit = 0;
            m_digit = (m_digit + 1) % N;
            light_at = n + B + 1;
        end else if (!m_lit && n == light_at) begin
            m_lit = 1;
            s_value = value;
            s_dp = dp_in;
            s_en = digit_en;
        end
    endtask

    function automatic logic [11:0] exp_out();
        bit         on;
        logic [3:0] nb;
        if (!m_lit) return {4'hF, 7'h7F, 1'b1};
        on = s_en[m_digit];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (m_digit > 0 && (s_value >> (4 * m_digit)) == 0) on = 0;
`endif
        nb = s_value[4*m_digit +: 4];
        return {~(4'b0001 << m_digit), on ? ~lit[nb] : 7'h7F, on ? ~s_dp[m_digit] : 1'b1};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out", {an, seg, dp}, exp_out());
        if (half > 0) begin
            hcnt++;
            if (hcnt >= half) begin
                hcnt = 0;
                scan_clk = ~scan_clk;
            end
        end
    endtask

    initial begin
        half = 0;
        value = 16'h1234;
        #22;
        check("reset", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) cyc();
        check("first_digit", {an, seg, dp}, {4'b1110, 7'h19, 1'b1});
        repeat (30) cyc();
        half = 8;
        repeat (140) cyc();
        value = 16'h00A0;
        dp_in = 4'b0010;
        repeat (90) cyc();
        value = 16'h1234;
        dp_in = '0;
        digit_en = 4'b1011;
        repeat (90) cyc();
        digit_en = '1;
        value = 16'h1111;
        for (int i = 0; i < 200 && !(m_lit && m_digit == 0); i++) cyc();
        check("reach_d0", an, 4'b1110);
        repeat (2) cyc();
        value = 16'h2222;
        repeat (90) cyc();
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) value = $urandom;
            if ($urandom_range(0, 31) == 0) value = $urandom_range(0, 255);
            if ($urandom_range(0, 31) == 0) dp_in = $urandom;
            if ($urandom_range(0, 31) == 0) digit_en = $urandom;
            if ($urandom_range(0, 199) == 0) half = $urandom_range(3, 14);
            cyc();
        end
        digit_en = '1;
        half = 8;
        for (int i = 0; i < 500 && !(m_lit && m_digit == 2); i++) cyc();
        check("reach_d2", an, 4'b1011);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        half = 0;
        scan_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) cyc();
        check("restart_d0", an, 4'b1110);
        repeat (20) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
